// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter fed by a byte strobe, with a 2-entry holding queue so that
// a high/low byte pair on consecutive cycles goes out as back-to-back frames.
`timescale 1ns/1ps

module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       TxEn,
    input  logic [7:0] TxData,
    output logic       Tx,
    output logic       TxBusy,
    output logic       TxDone,
    output logic       TxReady,
    output logic       TxOverflow
);

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_clk_cnt, w_clk_cnt_next;
    logic [2:0]    r_bit_cnt, w_bit_cnt_next;
    logic [7:0]    r_shift, w_shift_next;
    logic          r_tx, w_tx_next;

    logic [7:0]    r_q0, r_q1;
    logic [1:0]    r_q_count;
    logic          w_q_nonempty, w_bit_end, w_pop, w_push, w_done;

    assign w_q_nonempty = (r_q_count != 2'd0);
    assign w_bit_end    = (r_clk_cnt == LAST_CNT);
    // A pop frees a slot in the same cycle, so a full queue still takes a byte then.
    assign w_push       = TxEn && ((r_q_count != 2'd2) || w_pop);

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_next   = r_state;
        w_clk_cnt_next = r_clk_cnt;
        w_bit_cnt_next = r_bit_cnt;
        w_shift_next   = r_shift;
        w_pop          = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_q_nonempty) begin
                    w_pop          = 1'b1;
                    w_shift_next   = r_q0;
                    w_clk_cnt_next = '0;
                    w_bit_cnt_next = '0;
                    w_state_next   = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    w_state_next   = S_DATA;
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    w_shift_next   = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_done         = 1'b1;
                    w_clk_cnt_next = '0;
                    if (w_q_nonempty) begin
                        w_pop          = 1'b1;
                        w_shift_next   = r_q0;
                        w_bit_cnt_next = '0;
                        w_state_next   = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_clk_cnt_next = r_clk_cnt + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Line level for the state being entered, so the registered Tx tracks r_state.
    always_comb begin
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the values that were present before the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_q_count <= 2'd0;
        end else begin
            r_state   <= w_state_next;
            r_clk_cnt <= w_clk_cnt_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shift   <= w_shift_next;
            r_tx      <= w_tx_next;
            case ({w_push, w_pop})
                2'b10:   r_q_count <= r_q_count + 2'd1;
                2'b01:   r_q_count <= r_q_count - 2'd1;
                default: r_q_count <= r_q_count;
            endcase
        end
    end

    // NOTE: queue storage carries no reset; r_q_count alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push && w_pop) begin
            if (r_q_count == 2'd2) begin
                r_q0 <= r_q1;
                r_q1 <= TxData;
            end else begin
                r_q0 <= TxData;
            end
        end else if (w_pop) begin
            r_q0 <= r_q1;
        end else if (w_push) begin
            if (r_q_count == 2'd0) begin
                r_q0 <= TxData;
            end else begin
                r_q1 <= TxData;
            end
        end
    end

    assign Tx         = r_tx;
    assign TxBusy     = (r_state != S_IDLE);
    assign TxDone     = w_done;
    assign TxReady    = (r_q_count != 2'd2);
    assign TxOverflow = TxEn && (r_q_count == 2'd2) && !w_pop;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: one instance at 4 clocks/bit, one at the 2 clocks/bit minimum.
`timescale 1ns/1ps

module tb_uart_byte_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_en, b_en;
    logic [7:0] a_data, b_data;
    logic       a_tx, a_busy, a_done, a_ready, a_ovf;
    logic       b_tx, b_busy, b_done, b_ready, b_ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_byte_tx #(.CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .reset(reset), .TxEn(a_en), .TxData(a_data),
        .Tx(a_tx), .TxBusy(a_busy), .TxDone(a_done), .TxReady(a_ready), .TxOverflow(a_ovf)
    );

    uart_byte_tx #(.CLKS_PER_BIT(2)) dut_b (
        .clk(clk), .reset(reset), .TxEn(b_en), .TxData(b_data),
        .Tx(b_tx), .TxBusy(b_busy), .TxDone(b_done), .TxReady(b_ready), .TxOverflow(b_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Line level for bit slot idx (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    initial begin
        logic [9:0] pat_a5;
        logic [7:0] t3_bytes [3];
        logic [7:0] cur;

        pat_a5   = 10'b1101001010;
        t3_bytes = '{8'h01, 8'h02, 8'h03};

        reset  = 1'b0;
        a_en   = 1'b0;
        a_data = 8'h00;
        b_en   = 1'b0;
        b_data = 8'h00;
        @(negedge clk);
        step();
        step();

        check("rst_tx",     a_tx,    1);
        check("rst_busy",   a_busy,  0);
        check("rst_done",   a_done,  0);
        check("rst_ready",  a_ready, 1);
        check("rst_ovf",    a_ovf,   0);
        check("rst_b_tx",   b_tx,    1);
        check("rst_b_busy", b_busy,  0);
        check("rst_b_rdy",  b_ready, 1);
        reset = 1'b1;
        step();

        // 1: single byte 0xA5
        a_en = 1'b1; a_data = 8'hA5;
        step();
        a_en = 1'b0;
        check("t1_idle_tx",   a_tx,   1);
        check("t1_idle_busy", a_busy, 0);
        step();
        for (int k = 1; k <= 40; k++) begin
            check($sformatf("t1_tx@%0d", k),   a_tx,   pat_a5[(k-1)/4]);
            check($sformatf("t1_busy@%0d", k), a_busy, 1);
            check($sformatf("t1_done@%0d", k), a_done, (k == 40));
            step();
        end
        check("t1_end_tx",   a_tx,   1);
        check("t1_end_busy", a_busy, 0);
        check("t1_end_done", a_done, 0);

        // 2: byte pair 0x12, 0x34 on consecutive cycles
        a_en = 1'b1; a_data = 8'h12;
        #1 check("t2_ovf0", a_ovf, 0);
        step();
        a_data = 8'h34;
        #1 check("t2_ovf1", a_ovf, 0);
        step();
        a_en = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            cur = (k <= 40) ? 8'h12 : 8'h34;
            check($sformatf("t2_tx@%0d", k),   a_tx,   frame_bit(cur, ((k-1) % 40) / 4));
            check($sformatf("t2_busy@%0d", k), a_busy, 1);
            check($sformatf("t2_done@%0d", k), a_done, (k % 40 == 0));
            step();
        end
        check("t2_end_tx",   a_tx,   1);
        check("t2_end_busy", a_busy, 0);

        // 3: four bytes back to back, the fourth overflows
        a_en = 1'b1; a_data = 8'h01;
        #1 check("t3_ovf1", a_ovf, 0);
        step();
        a_data = 8'h02;
        #1 check("t3_ovf2", a_ovf, 0);
        check("t3_rdy2", a_ready, 1);
        step();
        a_data = 8'h03;
        #1 check("t3_ovf3", a_ovf, 0);
        check("t3_rdy3", a_ready, 1);
        step();
        a_data = 8'h04;
        #1 check("t3_ovf4", a_ovf, 1);
        check("t3_rdy4", a_ready, 0);
        step();
        a_en = 1'b0;
        #1 check("t3_ovf_clr", a_ovf, 0);
        for (int k = 3; k <= 120; k++) begin
            cur = t3_bytes[(k-1)/40];
            check($sformatf("t3_tx@%0d", k),   a_tx,    frame_bit(cur, ((k-1) % 40) / 4));
            check($sformatf("t3_done@%0d", k), a_done,  (k % 40 == 0));
            check($sformatf("t3_rdy@%0d", k),  a_ready, (k >= 41));
            step();
        end
        check("t3_end_tx",   a_tx,   1);
        check("t3_end_busy", a_busy, 0);

        // 4: reset during data bit 3 with one byte still queued
        a_en = 1'b1; a_data = 8'h3C;
        step();
        a_data = 8'h5A;
        step();
        a_en = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            check($sformatf("t4_tx@%0d", k), a_tx, frame_bit(8'h3C, (k-1) / 4));
            step();
        end
        check("t4_pre_busy", a_busy, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("t4_tx",    a_tx,    1);
        check("t4_busy",  a_busy,  0);
        check("t4_ready", a_ready, 1);
        check("t4_done",  a_done,  0);
        for (int k = 0; k < 60; k++) begin
            step();
            check($sformatf("t4_quiet@%0d", k), {a_tx, a_busy, a_done, a_ready}, 4'b1001);
        end

        // 5: push in the TxDone cycle with the queue empty
        a_en = 1'b1; a_data = 8'hC3;
        step();
        a_en = 1'b0;
        step();
        for (int k = 1; k <= 40; k++) begin
            check($sformatf("t5_tx@%0d", k),   a_tx,   frame_bit(8'hC3, (k-1) / 4));
            check($sformatf("t5_done@%0d", k), a_done, (k == 40));
            if (k == 40) begin
                a_en = 1'b1; a_data = 8'h55;
                #1 check("t5_push_rdy", a_ready, 1);
                check("t5_push_ovf", a_ovf, 0);
            end
            step();
        end
        a_en = 1'b0;
        check("t5_gap_tx",   a_tx,   1);
        check("t5_gap_busy", a_busy, 0);
        step();
        for (int k = 42; k <= 81; k++) begin
            check($sformatf("t5_tx@%0d", k),   a_tx,   frame_bit(8'h55, (k-42) / 4));
            check($sformatf("t5_busy@%0d", k), a_busy, 1);
            check($sformatf("t5_done@%0d", k), a_done, (k == 81));
            step();
        end
        check("t5_end_tx",   a_tx,   1);
        check("t5_end_busy", a_busy, 0);

        // 6: minimum rate, 2 clocks per bit, 0xFF
        b_en = 1'b1; b_data = 8'hFF;
        step();
        b_en = 1'b0;
        check("t6_idle_tx", b_tx, 1);
        step();
        for (int k = 1; k <= 20; k++) begin
            check($sformatf("t6_tx@%0d", k),   b_tx,   (k > 2));
            check($sformatf("t6_busy@%0d", k), b_busy, 1);
            check($sformatf("t6_done@%0d", k), b_done, (k == 20));
            step();
        end
        check("t6_end_tx",   b_tx,   1);
        check("t6_end_busy", b_busy, 0);
        check("t6_end_done", b_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_byte_tx.md
# uart_byte_tx

Serial-line transmitter that consumes the byte stream produced by the CPU-to-TX data filter (`TxEn` / `TxData`) and drives an 8N1 UART line. A 2-entry holding queue absorbs the high/low byte pair that the filter emits on consecutive cycles. Transmission is continuous, with no idle gap between queued frames. It sits between the data filter and the board TX pin, mirroring the receiver that feeds `RxDone` / `RxData`.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Legal range is 2 or more.

**Ports**
- `clk`  input  1: system clock; all logic on the rising edge.
- `reset`  input  1: synchronous, active-low reset. `reset == 0` at a rising edge resets the block.
- `TxEn`  input  1: byte-valid strobe; sampled every cycle.
- `TxData`  input  8: byte to send; captured when `TxEn == 1` and the byte is accepted.
- `Tx`  output  1: serial line; idle high.
- `TxBusy`  output  1: high while a frame is on the line (START through STOP).
- `TxDone`  output  1: one-cycle pulse in the cycle the stop bit of a frame completes.
- `TxReady`  output  1: high when the queue holds fewer than 2 bytes.
- `TxOverflow`  output  1: one-cycle pulse when an offered byte is dropped.

## Operation

**Reset values:** `Tx = 1`, `TxBusy = 0`, `TxDone = 0`, `TxReady = 1`, `TxOverflow = 0`. The queue is emptied, the FSM is in IDLE, and all counters are 0.

**Queue:** 2-entry FIFO with count 0..2.
- Push when `TxEn == 1` and (count < 2 or a pop occurs in the same cycle).
- `TxEn == 1` with count == 2 and no pop in that cycle: the byte is dropped and `TxOverflow` pulses. The queue is unchanged.
- A push and a pop in the same cycle leave count unchanged. Bytes leave in arrival order.

**FSM states:** IDLE, START, DATA, STOP.
- **IDLE:** `Tx = 1`. If the queue is non-empty, pop the head into the shift register, clear the bit counter and cycle counter, and go to START. Otherwise stay in IDLE.
- **START:** `Tx = 0` for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA:** `Tx` = shift-register bit 0, so bits go out LSB first. Each bit is held for `CLKS_PER_BIT` cycles, then the register shifts right. After 8 bits, go to STOP.
- **STOP:** `Tx = 1` for `CLKS_PER_BIT` cycles. On the last cycle, `TxDone = 1`:
  - If the queue is non-empty, pop and go directly to START (back-to-back frame).
  - Otherwise go to IDLE.
- **Outputs:**
  - `TxBusy = 1` in START, DATA and STOP.
  - `Tx` is registered. Its value reflects the state entered at the preceding edge.
- **Cycle counter:** counts 0..`CLKS_PER_BIT`−1 and wraps at each bit boundary. Its width is $\lceil\log_2(\text{CLKS\_PER\_BIT})\rceil$. The bit counter is 3 bits wide.
- **Reset mid-frame:** reset overrides every other condition. `Tx` returns high at the next edge, no `TxDone` is issued, and queued bytes are discarded.

## Timing

- **Latency:** `TxEn` is sampled at edge E0. The FSM leaves IDLE at E1, and `Tx` is low from E1. The start bit occupies cycles E1..E1+`CLKS_PER_BIT`−1.
- **Frame length:** exactly 10·`CLKS_PER_BIT` cycles. `TxDone` is high during the final cycle of the stop bit.
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the `TxDone` cycle. There are zero idle cycles and `TxBusy` stays high throughout.
- **Pop and `TxReady`:** a pop happens at the edge that leaves IDLE, or at the edge that leaves STOP into START. `TxReady` reflects the count after the preceding edge.
- **Simultaneous `TxEn` and `TxDone`:** the byte is accepted if count < 2 or a pop occurs in that same cycle.

## Test plan

1. **Single byte:** `CLKS_PER_BIT = 4`, one `TxEn` pulse with 0xA5 from idle.
   - Expected `Tx`, 4 cycles per bit, starting the cycle after the strobe: 0, 1, 0, 1, 0, 0, 1, 0, 1, 1.
   - `TxBusy` is high for 40 cycles. There is one `TxDone` pulse, in cycle 40.
2. **Byte pair:** 0x12 and 0x34 on consecutive cycles.
   - Both bytes are accepted with no overflow.
   - The line carries 80 continuous busy cycles, with 0x12 first, then 0x34.
   - `TxDone` pulses at cycles 40 and 80. `Tx` returns idle high afterwards.
3. **Overflow:** four bytes 0x01, 0x02, 0x03, 0x04 on consecutive cycles from idle.
   - The first three are transmitted in order.
   - 0x04 is dropped, with `TxOverflow` high exactly in its cycle.
   - `TxReady` is 0 from the cycle after the third byte's strobe until the next pop, at the start of frame 2.
4. **Reset mid-frame:** hold `reset = 0` for one cycle during DATA bit 3 of a frame, with one byte still queued.
   - At the next edge: `Tx = 1`, `TxBusy = 0`, `TxReady = 1`, queue empty.
   - No `TxDone` and no further frame follows.
5. **Push during `TxDone`:** assert `TxEn` with 0x55 in the `TxDone` cycle of a frame, with the queue empty.
   - The byte is accepted.
   - Its start bit begins the cycle after the next edge, with one idle-high cycle between frames.
6. **Minimum rate:** `CLKS_PER_BIT = 2`, byte 0xFF.
   - Expected `Tx`: 2 low cycles, 16 high data cycles, 2 high stop cycles.
   - `TxDone` pulses in cycle 20.
